// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with a 7-bit address.
// SCL/SDA are brought into the clk domain through SYNC_STAGES flops, and all
// bus decoding is done on those synchronised copies.
// Ports:
//   clk, reset_n      system clock; asynchronous active-low reset
//   scl_in, sda_in    raw bus levels (asynchronous)
//   sda_oe            1 = pull SDA low, 0 = release
//   own_addr          7-bit target address (quasi-static)
//   tx_data, tx_req   read data and its one-clk "about to load" strobe
//   rx_data, rx_valid last written byte and its one-clk update strobe
//   rw                R/W bit of the last matched address (1 = read)
//   busy              high from address ACK until STOP/START/NACK
module i2c_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] own_addr,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, WDATA, ACK_W, RDATA, ACK_R, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_rw;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_rx_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both samples so an SDA change racing an SCL edge
    // is never mistaken for a bus condition.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_pend  <= 1'b0;
        end else begin
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            // A completed write byte is published one clk after its 8th bit.
            if (r_rx_pend) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_rx_pend  <= 1'b0;
            end
            if (w_stop) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            // r_shift[6:0] already holds address bits 7..1
                            if (r_bit_cnt == 4'd7 && r_shift[6:0] == own_addr)
                                r_rw <= w_sda;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= '0;
                            if (r_shift[7:1] == own_addr) begin
                                r_state  <= ACK_ADDR;
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                                r_tx_req <= r_rw;
                            end else begin
                                r_state  <= WAIT_STOP;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_state  <= RDATA;
                                r_shift  <= tx_data;
                                r_sda_oe <= ~tx_data[7];
                            end else begin
                                r_state  <= WDATA;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    WDATA: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7)
                                r_rx_pend <= 1'b1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_state   <= ACK_W;
                            r_bit_cnt <= '0;
                            r_sda_oe  <= 1'b1;
                        end
                    end
                    ACK_W: begin
                        if (w_scl_fall) begin
                            r_state  <= WDATA;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    RDATA: begin
                        // r_shift[7] is the bit currently on the bus.
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_state   <= ACK_R;
                                r_bit_cnt <= '0;
                                r_sda_oe  <= 1'b0;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    ACK_R: begin
                        // Entered on a falling edge, so a falling edge seen
                        // here always follows an ACKed rising edge.
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_tx_req <= 1'b1;
                            end else begin
                                r_state <= WAIT_STOP;
                                r_busy  <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_state   <= RDATA;
                            r_bit_cnt <= '0;
                            r_shift   <= tx_data;
                            r_sda_oe  <= ~tx_data[7];
                        end
                    end
                    WAIT_STOP: r_sda_oe <= 1'b0;
                    default:   r_state  <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign tx_req   = r_tx_req;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rw       = r_rw;
    assign busy     = r_busy;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the scl_in/sda_in synchronisers (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; SCL/SDA are oversampled (clk >= 8x SCL rate).
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port scl_in  input  1  bus SCL level (asynchronous).
REQ-005 SHALL have port sda_in  input  1  bus SDA level (asynchronous).
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-007 SHALL have port own_addr  input  7  target address, quasi-static.
REQ-008 SHALL have port tx_data  input  8  byte to return on read.
REQ-009 SHALL have port tx_req  output  1  one-clk pulse: tx_data is about to be loaded.
REQ-010 SHALL have port rx_data  output  8  last byte written by master.
REQ-011 SHALL have port rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-012 SHALL have port rw  output  1  R/W bit of last matched address (1 = read).
REQ-013 SHALL have port busy  output  1  high from matched address ACK until STOP/START/NACK.

Function
REQ-014 SHALL synchronise scl_in/sda_in through SYNC_STAGES flops; all edge/condition detection uses the synchronised signals only.
REQ-015 SHALL detect START as synced SDA 1->0 while synced SCL high, STOP as SDA 0->1 while SCL high, in any state.
REQ-016 SHALL use FSM states IDLE, ADDR, ACK_ADDR, WDATA, ACK_W, RDATA, ACK_R, WAIT_STOP.
REQ-017 START from any state SHALL enter ADDR, clear bit counter, set sda_oe=0, busy=0 (repeated START supported).
REQ-018 STOP from any state SHALL enter IDLE, sda_oe=0, busy=0, including mid-byte; partial byte discarded, no rx_valid.
REQ-019 Bits SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on the clk following an SCL falling edge (or on START/STOP/reset).
REQ-020 ADDR: after 8th rising edge, if bits[7:1]==own_addr, latch rw=bit[0]; at next SCL falling edge assert sda_oe=1, busy=1, enter ACK_ADDR; on mismatch enter WAIT_STOP with sda_oe=0.
REQ-021 ACK_ADDR: at following SCL falling edge release ACK; rw=0 -> WDATA; rw=1 -> RDATA, load shift register from tx_data and drive first bit in the same clk.
REQ-022 tx_req SHALL pulse on the clk ACK is asserted (ACK_ADDR entry) and on the clk master ACK is sampled in ACK_R; tx_data SHALL be held stable from tx_req until the next SCL falling edge.
REQ-023 WDATA: after 8th rising edge, rx_data SHALL update and rx_valid pulse one clk later; at next falling edge sda_oe=1 (always ACK), enter ACK_W; following falling edge release, return to WDATA.
REQ-024 RDATA: sda_oe = NOT current shift bit (0 bit pulls low); after 8th bit's falling edge release SDA, enter ACK_R.
REQ-025 ACK_R: sample SDA on rising edge; low (ACK) -> pulse tx_req, reload tx_data at next falling edge, RDATA; high (NACK) -> WAIT_STOP, busy=0.
REQ-026 WAIT_STOP SHALL keep sda_oe=0 and ignore data until START or STOP.
REQ-027 Bit counter SHALL be 4 bits, reset to 0 on each byte boundary; no wrap across bytes.
REQ-028 START and STOP in the same synced sample is impossible; STOP SHALL win if both flagged.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, sda_oe=0, tx_req=0, rx_valid=0, rx_data=0x00, rw=0, busy=0, counters 0, synchroniser flops to 1.
REQ-030 Reset mid-transfer SHALL release SDA immediately; after release the block waits for a fresh START.

Verification
REQ-031 own_addr=0x42; START, 0x84, 0x55, STOP -> ACK on both 9th bits, rx_valid once, rx_data=0x55, rw=0.
REQ-032 own_addr=0x42; START, 0x86 (0x43 write), 0xAA -> sda_oe never asserted, no rx_valid, busy=0.
REQ-033 Read 0x85, tx_data 0x3C then 0xC3, master ACK then NACK -> SDA bits 00111100, 11000011; tx_req pulses twice; WAIT_STOP after NACK.
REQ-034 Write 0x84, 0x11, repeated START, 0x85 read -> rx_data=0x11, rw=1, ACK_ADDR reached, tx_req pulse.
REQ-035 STOP after 4 bits of a write data byte -> IDLE, no rx_valid, rx_data unchanged.
REQ-036 reset_n low during address ACK (sda_oe=1) -> sda_oe=0 same cycle, all outputs at reset values.
